// File: rtl/onehot_pkg.sv
// Shared constants for the one-hot constant mux and its inverse encoder.
// Both ends read TABLE from here so they can never disagree.
package onehot_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 8;

    localparam int TBL_N    = 4;
    localparam int TBL_W    = 5;
    localparam int SEXT_MAX = 32;

    // -3, -5, -7, -11 as 5-bit two's complement
    localparam logic [TBL_W-1:0] TABLE [TBL_N] = '{5'h1D, 5'h1B, 5'h19, 5'h15};

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_e;

    // Entries past the end of TABLE read as zero; callers size the result down.
    function automatic logic [SEXT_MAX-1:0] sextEntry(input int k);
        logic [TBL_W-1:0] e;
        e = '0;
        if (k >= 0 && k < TBL_N) begin
            e = TABLE[k];
        end
        return {{(SEXT_MAX-TBL_W){e[TBL_W-1]}}, e};
    endfunction

endpackage

// File: rtl/onehot_value_encoder.sv
// Finds the one-hot selector that makes the constant mux output a given value,
// scanning the shared table one entry per cycle behind valid/ready handshakes.
module onehot_value_encoder
    import onehot_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int W  = W_DEFAULT,
    parameter int CW = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_sel,
    output logic [$clog2(N)-1:0] out_index,
    output logic                 out_hit,
    output logic [CW-1:0]        miss_count
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  value_q, value_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cmpIdx_q, cmpIdx_d;
    logic          cmpValid_q, cmpValid_d;
    logic          eq_q, eq_d;
    logic [N-1:0]  sel_q, sel_d;
    logic [IW-1:0] index_q, index_d;
    logic          hit_q, hit_d;
    logic [CW-1:0] missCount_q, missCount_d;
    logic [W-1:0]  entryVal;

    assign entryVal = W'(sextEntry(int'(idx_q)));

    // The compare result is registered and judged a cycle later, which keeps
    // the table lookup and equality off the state-decision path.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        idx_d       = idx_q;
        cmpIdx_d    = cmpIdx_q;
        cmpValid_d  = 1'b0;
        eq_d        = eq_q;
        sel_d       = sel_q;
        index_d     = index_q;
        hit_d       = hit_q;
        missCount_d = missCount_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d = in_value;
                    idx_d   = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                eq_d       = (value_q == entryVal);
                cmpIdx_d   = idx_q;
                cmpValid_d = 1'b1;
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                end
                if (cmpValid_q) begin
                    if (eq_q) begin
                        sel_d      = N'(1) << cmpIdx_q;
                        index_d    = cmpIdx_q;
                        hit_d      = 1'b1;
                        cmpValid_d = 1'b0;
                        state_d    = DONE;
                    end else if (cmpIdx_q == LAST_IDX) begin
                        sel_d      = '0;
                        index_d    = '0;
                        hit_d      = 1'b0;
                        cmpValid_d = 1'b0;
                        state_d    = DONE;
                        if (missCount_q != '1) begin
                            missCount_d = missCount_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            value_q     <= '0;
            idx_q       <= '0;
            cmpIdx_q    <= '0;
            cmpValid_q  <= 1'b0;
            eq_q        <= 1'b0;
            sel_q       <= '0;
            index_q     <= '0;
            hit_q       <= 1'b0;
            missCount_q <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            idx_q       <= idx_d;
            cmpIdx_q    <= cmpIdx_d;
            cmpValid_q  <= cmpValid_d;
            eq_q        <= eq_d;
            sel_q       <= sel_d;
            index_q     <= index_d;
            hit_q       <= hit_d;
            missCount_q <= missCount_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_sel    = sel_q;
    assign out_index  = index_q;
    assign out_hit    = hit_q;
    assign miss_count = missCount_q;

endmodule
